// File: rtl/mmio_uart_pkg.sv
// Shared types and register offsets for the memory-mapped UART.
// Imported by the UART top, its bus interface users and the bench.
package mmio_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam logic [3:0] UART_TXDATA  = 4'h0;
    localparam logic [3:0] UART_STATUS  = 4'h4;
    localparam logic [3:0] UART_DIVISOR = 4'h8;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory port as seen by an MMIO responder.
// The core drives the master side; peripherals take the slave side.
interface mmio_uart_tx_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] wr_addr;
    logic             we;
    logic [2:0]       wr_bytes;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_addr;
    logic             re;
    logic [2:0]       rd_bytes;
    logic             rd_unsigned;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output wr_addr, we, wr_bytes, wr_data,
        output rd_addr, re, rd_bytes, rd_unsigned,
        input  rd_data
    );

    modport slave (
        input  wr_addr, we, wr_bytes, wr_data,
        input  rd_addr, re, rd_bytes, rd_unsigned,
        output rd_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers and a show-ahead head.
// A push while full is taken only when a pop frees a slot the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wp_q, rp_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign empty = (wp_q == rp_q);
    assign dout  = mem_q[rp_q[AW-1:0]];

    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter responding on the data-memory port.
// Register decode, load extension, TX FIFO and 8N1 serialiser.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR    = 32'h1000_0000,
    parameter int               CLKS_PER_BIT = 16,
    parameter int               FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx
);
    uart_tx_state_t state_q, state_d;

    logic [15:0]      div_q, div_d, div_new;
    logic [15:0]      lat_q, cnt_q;
    logic [7:0]       shift_q;
    logic [2:0]       idx_q;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d, rd_val;
    logic [3:0]       status_v;

    logic       w_hit, r_hit, push, pop, clr_ovf, div_we;
    logic       full, empty, busy, bit_done;
    logic [7:0] fifo_dout;
    logic       unused_bits;

    function automatic logic [WIDTH-1:0] ld_ext(
        input logic [WIDTH-1:0] v,
        input logic [2:0]       n,
        input logic             uns
    );
        case (n)
            3'd1:    return uns ? {{(WIDTH-8){1'b0}}, v[7:0]}
                                : {{(WIDTH-8){v[7]}}, v[7:0]};
            3'd2:    return uns ? {{(WIDTH-16){1'b0}}, v[15:0]}
                                : {{(WIDTH-16){v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    assign unused_bits = ^bus.wr_data[WIDTH-1:16];

    // Sub-word offsets never act: only addr[1:0]==0 hits a register.
    assign w_hit = bus.we &&
                   (bus.wr_addr[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]) &&
                   (bus.wr_addr[1:0] == 2'b00);
    assign r_hit = bus.re &&
                   (bus.rd_addr[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]) &&
                   (bus.rd_addr[1:0] == 2'b00);

    assign push    = w_hit && (bus.wr_addr[3:0] == UART_TXDATA);
    assign clr_ovf = w_hit && (bus.wr_addr[3:0] == UART_STATUS) &&
                     bus.wr_data[ST_OVF];
    assign div_we  = w_hit && (bus.wr_addr[3:0] == UART_DIVISOR);

    assign div_new = (bus.wr_bytes == 3'd1) ?
                     {div_q[15:8], bus.wr_data[7:0]} : bus.wr_data[15:0];
    assign div_d   = !div_we ? div_q :
                     (div_new == 16'd0) ? 16'd1 : div_new;

    // A dropped push sets overflow even if software clears it this cycle.
    assign ovf_d = (push && full && !pop) || (ovf_q && !clr_ovf);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.wr_data[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        status_v           = '0;
        status_v[ST_FULL]  = full;
        status_v[ST_EMPTY] = empty;
        status_v[ST_BUSY]  = busy;
        status_v[ST_OVF]   = ovf_q;
        rd_val             = '0;
        case (bus.rd_addr[3:0])
            UART_STATUS:  rd_val = {{(WIDTH-4){1'b0}}, status_v};
            UART_DIVISOR: rd_val = {{(WIDTH-16){1'b0}}, div_q};
            default:      rd_val = '0;
        endcase
        rd_data_d = r_hit ?
                    ld_ext(rd_val, bus.rd_bytes, bus.rd_unsigned) : '0;
    end

    assign bus.rd_data = rd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= 16'(CLKS_PER_BIT);
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign bit_done = (cnt_q == 16'd1);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: if (!empty) begin
                state_d = START;
                pop     = 1'b1;
            end
            START: if (bit_done) state_d = DATA;
            DATA:  if (bit_done && idx_q == 3'd7) state_d = STOP;
            STOP: if (bit_done) begin
                if (!empty) begin
                    state_d = START;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        tx   = 1'b1;
        unique case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    // Divisor is captured per frame so mid-frame writes wait a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 16'd1;
            lat_q   <= 16'd1;
            shift_q <= '0;
            idx_q   <= '0;
        end else if (pop) begin
            cnt_q   <= div_q;
            lat_q   <= div_q;
            shift_q <= fifo_dout;
            idx_q   <= '0;
        end else if (state_q != IDLE) begin
            if (bit_done) begin
                cnt_q <= lat_q;
                if (state_q == DATA) begin
                    shift_q <= shift_q >> 1;
                    idx_q   <= idx_q + 3'd1;
                end
            end else begin
                cnt_q <= cnt_q - 16'd1;
            end
        end
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the core's data-memory port as a responder. It accepts the same store/load signalling the core drives toward main memory (byte-counted writes, 1-cycle registered reads with sign/zero extension) and serialises bytes onto an 8N1 line. A top-level address decoder routes matching accesses here and ORs `rd_data` with main memory's read data.

## Interface
Parameters:
- `WIDTH`, 32: data/address width.
- `BASE_ADDR`, 32'h1000_0000: 16-byte aligned base; the block decodes `addr[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]`.
- `CLKS_PER_BIT`, 16: reset value of DIVISOR.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `wr_addr` in WIDTH: store address.
- `we` in 1: store strobe, one cycle per store.
- `wr_bytes` in 3: store size in bytes (1, 2 or 4).
- `wr_data` in WIDTH: store data, right-aligned.
- `rd_addr` in WIDTH: load address.
- `re` in 1: load strobe.
- `rd_bytes` in 3: load size in bytes (1, 2 or 4).
- `rd_unsigned` in 1: zero-extend (1) or sign-extend (0) sub-word loads.
- `rd_data` out WIDTH: registered load data.
- `tx` out 1: serial line, idle high.

## Operation
- Register map (offset = `addr[3:0]`; only `addr[1:0]==0` accesses act, others are ignored and read 0):
  - 0x0 TXDATA (W): pushes `wr_data[7:0]` into the FIFO. Reads return 0.
  - 0x4 STATUS (R/W1C): bit0 fifo_full, bit1 fifo_empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky). Writing 1 to bit3 clears it.
  - 0x8 DIVISOR (RW): bits[15:0], cycles per bit. A written value of 0 is stored as 1.
  - 0xC reserved: writes are ignored and reads return 0.
- Writes act on any `wr_bytes` value; only the low bytes actually written are meaningful.
- Loads: register value truncated to `rd_bytes`, then extended per `rd_unsigned`.
- Push while full (no pop the same cycle): byte dropped, overflow set.
- Push and pop in the same cycle while full: the push is accepted.
- Overflow set and W1C in the same cycle: set wins.
- FSM `uart_tx_state_t`: IDLE, START, DATA, STOP.
  - IDLE→START when the FIFO is non-empty. On this transition: pop the head, latch the byte into the shift register, latch DIVISOR into the bit-period counter.
  - START, then DATA (8 bits, LSB first, bit index 0..7), then STOP. Each bit is held for exactly the latched divisor in cycles.
  - STOP→START directly if the FIFO is non-empty, giving back-to-back frames with no idle bit. Otherwise STOP→IDLE.
- DIVISOR writes during a frame do not affect that frame; they apply from the next frame.

## Timing
- Reset values: `tx`=1, `rd_data`=0, FSM=IDLE, FIFO empty, overflow=0, DIVISOR=`CLKS_PER_BIT`.
- Load: `re` sampled at edge N → `rd_data` valid after edge N. `rd_data` is 0 after any edge where `re`=0 or the address misses the decode.
- Store at edge N: the FIFO shows non-empty from N. FSM pops at edge N+1, and `tx` falls from N+1.
- Frame length is 10×divisor cycles. `busy` is 1 from the START edge until the STOP bit completes.
- STATUS reflects state as of the previous edge; a push at edge N is visible to a load sampled at edge N+1.
- Reset asserted mid-frame: `tx` goes high immediately (asynchronous), the FIFO is flushed, the FSM enters IDLE, and no partial-frame resumption occurs.
- Wrap-around: FIFO pointers carry one extra bit; full = MSBs differ and indices equal.

## Structure
- Package `mmio_uart_pkg` holds:
  - `uart_tx_state_t`;
  - offsets `UART_TXDATA`=4'h0, `UART_STATUS`=4'h4, `UART_DIVISOR`=4'h8;
  - STATUS bit indices.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty; async active-high reset). It is reusable by a future RX block.
- The top module holds decode, registers, load-data extension and the serialiser FSM.

## Test plan
- DIVISOR=4, store 0x55 to TXDATA: `tx` low 4 cycles starting 1 cycle after the store, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles; `busy` high for 40 cycles.
- Stores 0x01,0x02 back-to-back: the second start bit immediately follows the first stop bit; the total line activity is 20×divisor cycles.
- 10 stores with no drain time: 8 FIFO entries plus 1 in the shift register are accepted, and the rest are dropped. STATUS reads 0x9 (full+overflow, busy bit2 set → 0xD). Storing 0x8 to STATUS then clears bit3.
- Write DIVISOR 0x8000, halfword load with `rd_unsigned`=0 → 0xFFFF8000; with `rd_unsigned`=1 → 0x00008000. Write 0 → reads back 1.
- Assert `rst` mid-DATA bit 3: `tx`=1 in the same cycle, and STATUS reads 0x2 after release; subsequent store 0xA5 transmits correctly.
- Load/store at `BASE_ADDR`+0x20 or an offset with `addr[1:0]`≠0: `rd_data`=0, no FIFO push, no register change.
